qdec_bs_fetch: RTL and testbench

//  Upstream feeder of the CABAC arithmetic decoder. Reads slice-data bytes from the

---
 rtl/qdec_bs_fetch.sv | 167 ++++++++++++++++
 tb/tb_qdec_bs_fetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_bs_fetch.sv
// Bitstream fetch front end for the CABAC arithmetic decoder.
// Optional EPB counter port enabled by QDEC_BSF_EPBCNT_EN.
module qdec_bs_fetch #(
  parameter int AW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] byte_len,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    bitstreamFetch,
  output logic          bitstreamFetch_vld,
  input  logic          bitstreamFetch_rdy,
  output logic          busy,
`ifdef QDEC_BSF_EPBCNT_EN
  output logic [AW-1:0] epb_cnt,
`endif
  output logic          done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FIN
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] base_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] off_q;
  logic          inflight;
  logic [1:0]    zr;
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic          start_acc;
  logic          room;
  logic          more;
  logic          last_rd;
  logic          is_epb;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;

  assign occ      = {1'b0, cnt} + {{CW{1'b0}}, inflight};
  assign room     = occ < (CW+1)'(FIFO_DEPTH);
  assign more     = off_q != len_q;
  assign mem_re   = (state == FETCH) && more && room;
  assign mem_addr = base_q + off_q;
  assign last_rd  = mem_re && ((off_q + AW'(1)) == len_q);

  assign is_epb = inflight && (zr == 2'd2)
                  && (mem_rdata == 8'h03);
  assign push   = inflight && !is_epb;

  assign bitstreamFetch_vld = cnt != '0;
  assign pop = bitstreamFetch_vld && bitstreamFetch_rdy;
  assign bitstreamFetch = bitstreamFetch_vld ? fifo[rd_ptr] : 8'h00;

  // segment sequencing: next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    start_acc = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = (byte_len == '0) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        busy = 1'b1;
        if (last_rd) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!inflight &&
            (cnt == '0 || (cnt == CW'(1) && pop)))
          state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // read sequencing and emulation-prevention tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      off_q    <= '0;
      inflight <= 1'b0;
      zr       <= 2'd0;
    end else begin
      if (start_acc) begin
        base_q <= base_addr;
        len_q  <= byte_len;
        off_q  <= '0;
        zr     <= 2'd0;
      end else if (mem_re) begin
        off_q <= off_q + AW'(1);
      end
      inflight <= mem_re;
      if (is_epb)
        zr <= 2'd0;
      else if (inflight)
        zr <= (mem_rdata != 8'h00) ? 2'd0 :
              (zr == 2'd2) ? 2'd2 : zr + 2'd1;
    end
  end

`ifdef QDEC_BSF_EPBCNT_EN
  // removed-EPB count, saturating, held after the segment
  always_ff @(posedge clk) begin
    if (rst)
      epb_cnt <= '0;
    else if (start_acc)
      epb_cnt <= '0;
    else if (is_epb && epb_cnt != '1)
      epb_cnt <= epb_cnt + AW'(1);
  end
`endif

  // output FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_rdata;
  end

  // output FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_qdec_bs_fetch.sv
// Scoreboard bench for qdec_bs_fetch.
// Covers EPB stripping, backpressure, address wrap, empty and reset.
module tb_qdec_bs_fetch;
  localparam int AW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] byte_len;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic [7:0]    bitstreamFetch;
  logic          bitstreamFetch_vld;
  logic          bitstreamFetch_rdy;
  logic          busy;
  logic          done;
`ifdef QDEC_BSF_EPBCNT_EN
  logic [AW-1:0] epb_cnt;
`endif

  qdec_bs_fetch #(.AW(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .byte_len(byte_len),
    .mem_addr(mem_addr),
    .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .bitstreamFetch(bitstreamFetch),
    .bitstreamFetch_vld(bitstreamFetch_vld),
    .bitstreamFetch_rdy(bitstreamFetch_rdy),
    .busy(busy),
`ifdef QDEC_BSF_EPBCNT_EN
    .epb_cnt(epb_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_xfer = 0;
  int reads = 0;
  int pops = 0;
  int max_occ = 0;
  logic [7:0]    exp_q [$];
  logic [AW-1:0] addr_log [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // monitor: scoreboard pops, read/done bookkeeping
  always @(negedge clk) begin
    if (!rst) begin
      if (bitstreamFetch_vld && bitstreamFetch_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra actual=%0h required=none",
                   bitstreamFetch);
        end else begin
          chk("sb_byte", {24'h0, bitstreamFetch},
              {24'h0, exp_q.pop_front()});
        end
        pops++;
        last_xfer = cyc;
      end
      if (mem_re) begin
        reads++;
        addr_log.push_back(mem_addr);
      end
      if (reads - pops > max_occ) max_occ = reads - pops;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_seg(input logic [AW-1:0] b,
                           input logic [AW-1:0] l,
                           output int t);
    @(posedge clk); #1;
    base_addr = b;
    byte_len  = l;
    start     = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 16'hDEAD;
    byte_len  = 16'h0033;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != n0) break;
    end
    chk(name, done_cnt - n0, 1);
    @(negedge clk);
    chk({name, "_pulse"}, {31'h0, done}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t;
    int r0;
    int d0;
    logic [7:0] v2 [8];
    logic [7:0] e2 [6];
    logic [AW-1:0] a4 [4];

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    byte_len = '0;
    bitstreamFetch_rdy = 1'b0;
    mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", {31'h0, bitstreamFetch_vld}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_re", {31'h0, mem_re}, 0);
    chk("rst_byte", {24'h0, bitstreamFetch}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: plain bytes, latency
    ram[16'h0010] = 8'h11;
    ram[16'h0011] = 8'h22;
    ram[16'h0012] = 8'h33;
    ram[16'h0013] = 8'h44;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    bitstreamFetch_rdy = 1'b1;
    start_seg(16'h0010, 16'd4, t);
    @(negedge clk);
    chk("t1_re_t1", {31'h0, mem_re}, 1);
    chk("t1_addr_t1", {16'h0, mem_addr}, 32'h10);
    chk("t1_busy_t1", {31'h0, busy}, 1);
    @(negedge clk);
    chk("t1_vld_t2", {31'h0, bitstreamFetch_vld}, 0);
    @(negedge clk);
    chk("t1_vld_t3", {31'h0, bitstreamFetch_vld}, 1);
    chk("t1_cyc_t3", cyc, t + 3);
    wait_done("t1_done", 50);
    chk("t1_done_time", done_cyc, last_xfer + 1);
    chk("t1_sb_empty", exp_q.size(), 0);

    // 2: emulation-prevention removal
    v2 = '{8'h00, 8'h00, 8'h03, 8'h01,
           8'h00, 8'h00, 8'h03, 8'h03};
    e2 = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03};
    for (int i = 0; i < 8; i++) ram[16'h0100 + i] = v2[i];
    for (int i = 0; i < 6; i++) exp_q.push_back(e2[i]);
    start_seg(16'h0100, 16'd8, t);
    wait_done("t2_done", 80);
    chk("t2_sb_empty", exp_q.size(), 0);
`ifdef QDEC_BSF_EPBCNT_EN
    chk("t2_epb_cnt", {16'h0, epb_cnt}, 2);
`endif

    // 3: backpressure
    for (int i = 0; i < 6; i++) begin
      ram[16'h0200 + i] = 8'hA1 + 8'(i);
      exp_q.push_back(8'hA1 + 8'(i));
    end
    @(posedge clk); #1;
    bitstreamFetch_rdy = 1'b0;
    reads = 0;
    pops = 0;
    max_occ = 0;
    start_seg(16'h0200, 16'd6, t);
    repeat (20) @(negedge clk);
    chk("t3_reads_stalled", reads, D);
    chk("t3_head", {24'h0, bitstreamFetch}, 32'hA1);
    chk("t3_vld_held", {31'h0, bitstreamFetch_vld}, 1);
    @(posedge clk); #1;
    bitstreamFetch_rdy = 1'b1;
    wait_done("t3_done", 80);
    chk("t3_occ_le_depth", {31'h0, max_occ <= D}, 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: address wrap
    a4 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      ram[a4[i]] = 8'h5A + 8'(i);
      exp_q.push_back(8'h5A + 8'(i));
    end
    addr_log.delete();
    start_seg(16'hFFFE, 16'd4, t);
    wait_done("t4_done", 50);
    chk("t4_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size())
        chk("t4_addr", {16'h0, addr_log[i]}, {16'h0, a4[i]});
    end
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5: empty segment
    r0 = reads;
    start_seg(16'h0300, 16'd0, t);
    @(negedge clk);
    chk("t5_busy_t1", {31'h0, busy}, 1);
    chk("t5_done_t1", {31'h0, done}, 0);
    chk("t5_re_t1", {31'h0, mem_re}, 0);
    @(negedge clk);
    chk("t5_done_t2", {31'h0, done}, 1);
    chk("t5_busy_t2", {31'h0, busy}, 0);
    @(negedge clk);
    chk("t5_done_t3", {31'h0, done}, 0);
    chk("t5_no_reads", reads - r0, 0);

    // 6: reset mid-fetch
    for (int i = 0; i < 6; i++) ram[16'h0400 + i] = 8'hE0 + 8'(i);
    @(posedge clk); #1;
    bitstreamFetch_rdy = 1'b0;
    start_seg(16'h0400, 16'd6, t);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_pre_vld", {31'h0, bitstreamFetch_vld}, 1);
    chk("t6_pre_busy", {31'h0, busy}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("t6_vld", {31'h0, bitstreamFetch_vld}, 0);
    chk("t6_busy", {31'h0, busy}, 0);
    chk("t6_done", {31'h0, done}, 0);
    repeat (5) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    for (int i = 0; i < 3; i++) begin
      ram[16'h0500 + i] = 8'hC1 + 8'(i);
      exp_q.push_back(8'hC1 + 8'(i));
    end
    @(posedge clk); #1;
    bitstreamFetch_rdy = 1'b1;
    start_seg(16'h0500, 16'd3, t);
    wait_done("t6_restart_done", 50);
    chk("t6_sb_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
